// File: rtl/pd_result_ddr_reader.sv
// Walks the detector's DDR result list from BASE_ADDR+1 to the zero terminator
// and streams each record out as a full-resolution bounding box.
module pd_result_ddr_reader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0900_0000,
  parameter int          MAX_RECORDS = 256,
  parameter int          WINDOW_W    = 70,
  parameter int          WINDOW_H    = 150
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [8:0]  rec_count,
  output logic [8:0]  err_count,
  output logic [31:0] DDR_READ_ADDR,
  output logic        DDR_READ_REQ,
  input  logic        DDR_READ_READY,
  input  logic [31:0] DDR_READ_DATA,
  output logic        box_valid,
  input  logic        box_ready,
  output logic [11:0] box_x,
  output logic [11:0] box_y,
  output logic [9:0]  box_w,
  output logic [9:0]  box_h,
  output logic [9:0]  box_grade,
  output logic [2:0]  box_scale
);

  typedef enum logic [2:0] {IDLE, REQ, DECODE, OUT, FIN} state_t;

  localparam logic [9:0]  WIN_W    = 10'(WINDOW_W);
  localparam logic [9:0]  WIN_H    = 10'(WINDOW_H);
  localparam logic [9:0]  REC_CAP  = 10'(MAX_RECORDS);
  // Word cap guards against a list that was never terminated.
  localparam logic [10:0] WORD_CAP = 11'(2 * MAX_RECORDS);

  function automatic logic [1:0] shift_of(input logic [1:0] code);
    case (code)
      2'b11:   shift_of = 2'd2;
      2'b10:   shift_of = 2'd1;
      default: shift_of = 2'd0;
    endcase
  endfunction

  function automatic logic [11:0] scale_pos(input logic [9:0] v, input logic [1:0] s);
    scale_pos = {2'b00, v} << s;
  endfunction

  function automatic logic [9:0] scale_win(input logic [9:0] v, input logic [1:0] s);
    scale_win = v << s;
  endfunction

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    sat_inc9 = (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] word_q, word_d;
  logic [10:0] word_cnt_q, word_cnt_d;
  logic [8:0]  rec_q, rec_d;
  logic [8:0]  err_q, err_d;
  logic        ovf_q, ovf_d;
  logic        bvalid_q, bvalid_d;
  logic [11:0] bx_q, bx_d;
  logic [11:0] by_q, by_d;
  logic [9:0]  bw_q, bw_d;
  logic [9:0]  bh_q, bh_d;
  logic [9:0]  bg_q, bg_d;
  logic [2:0]  bs_q, bs_d;
  logic [1:0]  shift_s;
  logic        last_rec_s;
  logic        word_cap_s;

  assign shift_s    = shift_of(word_q[31:30]);
  assign last_rec_s = (({1'b0, rec_q} + 10'd1) == REC_CAP);
  assign word_cap_s = (word_cnt_q >= WORD_CAP);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    req_d      = req_q;
    word_d     = word_q;
    word_cnt_d = word_cnt_q;
    rec_d      = rec_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    bvalid_d   = bvalid_q;
    bx_d       = bx_q;
    by_d       = by_q;
    bw_d       = bw_q;
    bh_d       = bh_q;
    bg_d       = bg_q;
    bs_d       = bs_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = REQ;
          addr_d     = BASE_ADDR + 32'd1;
          req_d      = 1'b1;
          word_cnt_d = '0;
          rec_d      = '0;
          err_d      = '0;
          ovf_d      = 1'b0;
        end
      end

      REQ: begin
        if (DDR_READ_READY) begin
          word_d     = DDR_READ_DATA;
          word_cnt_d = word_cnt_q + 11'd1;
          req_d      = 1'b0;
          state_d    = DECODE;
        end
      end

      DECODE: begin
        if (word_q == 32'h0) begin
          state_d = FIN;
        end else if (word_q[31:30] == 2'b00) begin
          err_d = sat_inc9(err_q);
          if (word_cap_s) begin
            ovf_d   = 1'b1;
            state_d = FIN;
          end else begin
            addr_d  = addr_q + 32'd1;
            req_d   = 1'b1;
            state_d = REQ;
          end
        end else begin
          bx_d     = scale_pos(word_q[19:10], shift_s);
          by_d     = scale_pos(word_q[9:0], shift_s);
          bw_d     = scale_win(WIN_W, shift_s);
          bh_d     = scale_win(WIN_H, shift_s);
          bg_d     = word_q[29:20];
          bs_d     = 3'b001 << shift_s;
          bvalid_d = 1'b1;
          state_d  = OUT;
        end
      end

      OUT: begin
        if (box_ready) begin
          bvalid_d = 1'b0;
          rec_d    = rec_q + 9'd1;
          if (last_rec_s || word_cap_s) begin
            ovf_d   = 1'b1;
            state_d = FIN;
          end else begin
            addr_d  = addr_q + 32'd1;
            req_d   = 1'b1;
            state_d = REQ;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        req_d    = 1'b0;
        bvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= BASE_ADDR;
      req_q      <= 1'b0;
      word_q     <= '0;
      word_cnt_q <= '0;
      rec_q      <= '0;
      err_q      <= '0;
      ovf_q      <= 1'b0;
      bvalid_q   <= 1'b0;
      bx_q       <= '0;
      by_q       <= '0;
      bw_q       <= '0;
      bh_q       <= '0;
      bg_q       <= '0;
      bs_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      word_q     <= word_d;
      word_cnt_q <= word_cnt_d;
      rec_q      <= rec_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      bvalid_q   <= bvalid_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      bw_q       <= bw_d;
      bh_q       <= bh_d;
      bg_q       <= bg_d;
      bs_q       <= bs_d;
    end
  end

  assign busy          = (state_q == REQ) || (state_q == DECODE) || (state_q == OUT);
  assign done          = (state_q == FIN);
  assign overflow      = ovf_q;
  assign rec_count     = rec_q;
  assign err_count     = err_q;
  assign DDR_READ_ADDR = addr_q;
  assign DDR_READ_REQ  = req_q;
  assign box_valid     = bvalid_q;
  assign box_x         = bx_q;
  assign box_y         = by_q;
  assign box_w         = bw_q;
  assign box_h         = bh_q;
  assign box_grade     = bg_q;
  assign box_scale     = bs_q;

endmodule

// File: doc/pd_result_ddr_reader.md
Name: pd_result_ddr_reader

Overview:
- Read-back end of the pedestrian-detection result list that the HOG/SVM detector writes into DDR.
- On each start request, walks the list word by word over a DDR read port, starting at BASE_ADDR+1 and stopping at the all-zero terminator word.
- Decodes each record into a full-resolution bounding box (scale-corrected position and window size, plus grade).
- Presents boxes on a valid/ready stream for the overlay/box-drawing logic.

Parameters:
- BASE_ADDR, 32'h0900_0000: list base word address; first record is at BASE_ADDR+1.
- MAX_RECORDS, 256: hard cap on records read per pass.
- WINDOW_W, 70: detection window width at 1:1 scale.
- WINDOW_H, 150: detection window height at 1:1 scale.

Ports:
- sys_clk, input, 1: single clock for all logic.
- sys_rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse; begins a read pass.
- busy, output, 1: high from the cycle after an accepted start until done.
- done, output, 1: one-cycle pulse at end of pass.
- overflow, output, 1: pass ended on MAX_RECORDS, not on the terminator; held until next start.
- rec_count, output, 9: boxes emitted in the current/last pass.
- err_count, output, 9: records skipped as malformed in the current/last pass.
- DDR_READ_ADDR, output, 32: word address.
- DDR_READ_REQ, output, 1: read request, held until DDR_READ_READY.
- DDR_READ_READY, input, 1: one-cycle pulse; DDR_READ_DATA is valid in the same cycle.
- DDR_READ_DATA, input, 32: read word.
- box_valid, output, 1: box stream valid.
- box_ready, input, 1: box stream ready.
- box_x, output, 12: top-left column at full resolution.
- box_y, output, 12: top-left row at full resolution.
- box_w, output, 10: window width at full resolution.
- box_h, output, 10: window height at full resolution.
- box_grade, output, 10: SVM grade/1024.
- box_scale, output, 3: 1 = 1:1, 2 = 1:2, 4 = 1:4.

Behaviour:
- Reset (async, any state): FSM goes to IDLE. All outputs are 0 except DDR_READ_ADDR, which resets to BASE_ADDR. DDR_READ_REQ and box_valid drop immediately; an in-flight read is abandoned.
- Record format: [31:30] scale code (11 = 1:4, 10 = 1:2, 01 = 1:1, 00 = invalid), [29:20] grade, [19:10] HCnt, [9:0] VCnt. The value 32'h0 is the terminator.
- Shift amount s = 2/1/0 for codes 11/10/01.
- box_x = HCnt<<s, box_y = VCnt<<s, box_w = WINDOW_W<<s, box_h = WINDOW_H<<s, all zero-extended.
- box_scale = 1<<s. box_grade = bits [29:20].
- FSM states: IDLE, REQ, DECODE, OUT, FIN.
- IDLE:
  - start=1 → REQ next cycle, with busy=1, DDR_READ_ADDR=BASE_ADDR+1, DDR_READ_REQ=1.
  - rec_count, err_count and overflow clear in the same transition.
- REQ: hold ADDR and REQ stable. In the cycle READY=1, capture DDR_READ_DATA → DECODE; REQ is 0 from the next cycle on.
- DECODE (one cycle), three cases:
  - Word == 0 → FIN.
  - Code 00 with nonzero word → err_count+1 (saturates at 511), ADDR+1, REQ=1 → REQ.
  - Otherwise load the box registers, box_valid=1 → OUT.
- OUT: box fields are stable while box_valid=1. On box_valid && box_ready:
  - box_valid=0 next cycle and rec_count+1.
  - If the new rec_count == MAX_RECORDS → overflow=1 → FIN.
  - Else ADDR+1, REQ=1 → REQ.
- FIN: done=1 for one cycle, busy=0 → IDLE. DDR_READ_ADDR keeps its last value.
- Latency: start at cycle 0 → REQ at cycle 1. READY at cycle k → box_valid at cycle k+2.
- start while busy is ignored; no queued restart.
- start in the same cycle as FIN → ignored; it is accepted only in IDLE.
- Malformed records do not count toward MAX_RECORDS, but the address cap also applies: after MAX_RECORDS+MAX_RECORDS total words read, go to FIN with overflow=1. This guards against a list with no terminator.
- box_ready is ignored outside OUT. box_valid never drops without a handshake, except on reset.

Test Plan:
- Three-record list: words at 0x0900_0001..0003 = 0xC0A0_5014, 0x8040_C832, 0x0 → two boxes.
  - Box 1: scale 4, x=80, y=80, w=280, h=600, grade 10.
  - Box 2: scale 2, x=100, y=100, w=140, h=300, grade 4.
  - Then done pulse, rec_count=2, overflow=0. Check READY@k → box_valid@k+2.
- Empty list (BASE+1 = 0) → no box_valid, done pulse, rec_count=0, exactly one read issued at 0x0900_0001.
- Backpressure: box_ready low for 20 cycles → box fields stable, no new DDR_READ_REQ until the handshake completes.
- Malformed word 0x0000_1234 between two valid records → err_count=1, rec_count=2, both valid boxes emitted.
- No terminator: 300 valid records → exactly 256 boxes, overflow=1, done pulse.
- Reset mid-REQ with DDR_READ_REQ=1, and start pulsed while busy:
  - Reset → REQ=0 immediately, ADDR=0x0900_0000, idle.
  - Start while busy → no effect on the address sequence.
